// File: rtl/output_queues_demux.sv
// Egress demux: one AXI-Stream input fanned out into NUM_QUEUES independent FWFT queues.
// Routing is decided once per packet at SOP; packets no selected port can absorb are dropped.
module oq_fifo #(
  parameter int W     = 417,
  parameter int AW    = 7,
  parameter int MAXW  = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         wr,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         pfull
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, free;
  logic          we, re;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign free  = (AW+1)'(DEPTH) - cnt;
  // Headroom for one maximum-size packet, judged only at SOP by the caller
  assign pfull = (free < (AW+1)'(MAXW));
  assign we    = wr & ~full;
  assign re    = rd & ~empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (we) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      case ({we, re})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module output_queues_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int DST_POS              = 24,
  parameter int MAX_PKT_WORDS        = 63,
  parameter int FIFO_DEPTH_BIT       = 7
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                              m_axis_tvalid_0,
  input  logic                              m_axis_tready_0,
  output logic                              m_axis_tlast_0,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                              m_axis_tvalid_1,
  input  logic                              m_axis_tready_1,
  output logic                              m_axis_tlast_1,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                              m_axis_tvalid_2,
  input  logic                              m_axis_tready_2,
  output logic                              m_axis_tlast_2,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                              m_axis_tvalid_3,
  input  logic                              m_axis_tready_3,
  output logic                              m_axis_tlast_3,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
  output logic                              m_axis_tvalid_4,
  input  logic                              m_axis_tready_4,
  output logic                              m_axis_tlast_4,
  output logic                              pkt_stored,
  output logic                              pkt_dropped
);
  localparam int DW      = C_S_AXIS_DATA_WIDTH;
  localparam int SW      = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW      = C_S_AXIS_TUSER_WIDTH;
  localparam int ENTRY_W = 1 + UW + SW + DW;

  typedef enum logic [1:0] {IDLE, WR_PKT, DROP_PKT} state_t;

  state_t                                 state;
  logic [NUM_QUEUES-1:0]                  dst_mask, mask_eff, req, acc;
  logic [NUM_QUEUES-1:0]                  wr_en, rd_en, rdy, empty, full, pfull;
  logic [NUM_QUEUES-1:0][ENTRY_W-1:0]     head;
  logic [ENTRY_W-1:0]                     din;
  logic                                   beat;

  // Admission control is by dropping, so the input is always ready out of reset
  assign s_axis_tready = axi_resetn;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign req           = s_axis_tuser[DST_POS +: NUM_QUEUES];
  assign acc           = req & ~pfull;
  assign din           = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign rdy           = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                          m_axis_tready_1, m_axis_tready_0};

  always_comb begin
    mask_eff = '0;
    case (state)
      IDLE:    mask_eff = acc;
      WR_PKT:  mask_eff = dst_mask;
      default: mask_eff = '0;
    endcase
  end

  assign wr_en = {NUM_QUEUES{beat}} & mask_eff & ~full;
  assign rd_en = rdy & ~empty;

  genvar g;
  generate
    for (g = 0; g < NUM_QUEUES; g++) begin : g_q
      oq_fifo #(.W(ENTRY_W), .AW(FIFO_DEPTH_BIT), .MAXW(MAX_PKT_WORDS)) u_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_resetn),
        .din   (din),
        .wr    (wr_en[g]),
        .rd    (rd_en[g]),
        .dout  (head[g]),
        .empty (empty[g]),
        .full  (full[g]),
        .pfull (pfull[g])
      );
    end
  endgenerate

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state       <= IDLE;
      dst_mask    <= '0;
      pkt_stored  <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      pkt_stored  <= 1'b0;
      pkt_dropped <= 1'b0;
      if (beat) begin
        case (state)
          IDLE: begin
            if (acc != '0) begin
              dst_mask   <= acc;
              pkt_stored <= 1'b1;
              if (!s_axis_tlast) state <= WR_PKT;
            end else begin
              pkt_dropped <= 1'b1;
              if (!s_axis_tlast) state <= DROP_PKT;
            end
          end
          WR_PKT:   if (s_axis_tlast) state <= IDLE;
          DROP_PKT: if (s_axis_tlast) state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tvalid_0 = ~empty[0];
  assign m_axis_tvalid_1 = ~empty[1];
  assign m_axis_tvalid_2 = ~empty[2];
  assign m_axis_tvalid_3 = ~empty[3];
  assign m_axis_tvalid_4 = ~empty[4];

  assign {m_axis_tlast_0, m_axis_tuser_0, m_axis_tstrb_0, m_axis_tdata_0} = head[0];
  assign {m_axis_tlast_1, m_axis_tuser_1, m_axis_tstrb_1, m_axis_tdata_1} = head[1];
  assign {m_axis_tlast_2, m_axis_tuser_2, m_axis_tstrb_2, m_axis_tdata_2} = head[2];
  assign {m_axis_tlast_3, m_axis_tuser_3, m_axis_tstrb_3, m_axis_tdata_3} = head[3];
  assign {m_axis_tlast_4, m_axis_tuser_4, m_axis_tstrb_4, m_axis_tdata_4} = head[4];
endmodule

// File: tb/tb_output_queues_demux.sv
// Directed and random packet traffic against a per-port queue reference model.
module tb_output_queues_demux;
  localparam int DW = 256, SW = 32, UW = 128, NQ = 5, EW = 1 + UW + SW + DW;
  localparam int DEPTH = 128, MAXW = 63;
  typedef logic [EW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0;
  logic          s_tready;
  logic [NQ-1:0] rdy = '1;
  logic [NQ-1:0] tvalid;
  logic [NQ-1:0] tlast;
  logic [DW-1:0] tdata [NQ];
  logic [SW-1:0] tstrb [NQ];
  logic [UW-1:0] tuser [NQ];
  logic          pkt_stored, pkt_dropped;

  ent_t          q [NQ][$];
  logic          in_pkt = 1'b0;
  logic [NQ-1:0] cur = '0;
  logic          exp_st = 1'b0, exp_dr = 1'b0;
  logic          rand_rdy = 1'b0;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  output_queues_demux dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata_0(tdata[0]), .m_axis_tstrb_0(tstrb[0]), .m_axis_tuser_0(tuser[0]),
    .m_axis_tvalid_0(tvalid[0]), .m_axis_tready_0(rdy[0]), .m_axis_tlast_0(tlast[0]),
    .m_axis_tdata_1(tdata[1]), .m_axis_tstrb_1(tstrb[1]), .m_axis_tuser_1(tuser[1]),
    .m_axis_tvalid_1(tvalid[1]), .m_axis_tready_1(rdy[1]), .m_axis_tlast_1(tlast[1]),
    .m_axis_tdata_2(tdata[2]), .m_axis_tstrb_2(tstrb[2]), .m_axis_tuser_2(tuser[2]),
    .m_axis_tvalid_2(tvalid[2]), .m_axis_tready_2(rdy[2]), .m_axis_tlast_2(tlast[2]),
    .m_axis_tdata_3(tdata[3]), .m_axis_tstrb_3(tstrb[3]), .m_axis_tuser_3(tuser[3]),
    .m_axis_tvalid_3(tvalid[3]), .m_axis_tready_3(rdy[3]), .m_axis_tlast_3(tlast[3]),
    .m_axis_tdata_4(tdata[4]), .m_axis_tstrb_4(tstrb[4]), .m_axis_tuser_4(tuser[4]),
    .m_axis_tvalid_4(tvalid[4]), .m_axis_tready_4(rdy[4]), .m_axis_tlast_4(tlast[4]),
    .pkt_stored(pkt_stored), .pkt_dropped(pkt_dropped)
  );

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rnd_user();
    logic [UW-1:0] u;
    for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
    return u;
  endfunction

  task automatic chk(input string tag, input ent_t obs, input ent_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NQ; n++) q[n].delete();
    in_pkt = 1'b0;
    cur    = '0;
    exp_st = 1'b0;
    exp_dr = 1'b0;
  endtask

  // One clock: compare outputs against the model, apply this cycle's traffic
  // to the model, then advance to just after the next rising edge.
  task automatic tick();
    int            sz [NQ];
    logic [NQ-1:0] req, acc;
    logic          nst, ndr;
    ent_t          e;
    if (rand_rdy) rdy = NQ'($urandom);
    chk("s_tready", ent_t'(s_tready), ent_t'(1'b1));
    for (int n = 0; n < NQ; n++) begin
      sz[n] = q[n].size();
      chk($sformatf("tvalid%0d", n), ent_t'(tvalid[n]), ent_t'(sz[n] != 0));
      if (sz[n] != 0) begin
        chk($sformatf("head%0d", n), {tlast[n], tuser[n], tstrb[n], tdata[n]}, q[n][0]);
        if (rdy[n]) void'(q[n].pop_front());
      end
    end
    chk("pkt_stored", ent_t'(pkt_stored), ent_t'(exp_st));
    chk("pkt_dropped", ent_t'(pkt_dropped), ent_t'(exp_dr));
    nst = 1'b0;
    ndr = 1'b0;
    if (s_tvalid) begin
      if (!in_pkt) begin
        req = s_tuser[24 +: NQ];
        for (int n = 0; n < NQ; n++) acc[n] = req[n] && (DEPTH - sz[n] >= MAXW);
        cur = acc;
        nst = (acc != 0);
        ndr = (acc == 0);
      end
      e = {s_tlast, s_tuser, s_tstrb, s_tdata};
      for (int n = 0; n < NQ; n++)
        if (cur[n] && sz[n] < DEPTH) q[n].push_back(e);
      in_pkt = !s_tlast;
    end
    @(posedge clk);
    #1;
    exp_st = nst;
    exp_dr = ndr;
  endtask

  task automatic drive_beat(input logic [NQ-1:0] dst, input bit sop, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = rnd_data();
    s_tstrb  = SW'($urandom);
    s_tuser  = rnd_user();
    if (sop) s_tuser[24 +: NQ] = dst;
    s_tlast  = last;
  endtask

  task automatic send_pkt(input logic [NQ-1:0] dst, input int len, input bit bubbles);
    for (int i = 0; i < len; i++) begin
      drive_beat(dst, i == 0, i == len - 1);
      tick();
      if (bubbles && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        tick();
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, ent_t'(tvalid), '0);
    chk({tag, "_stored"}, ent_t'(pkt_stored), '0);
    chk({tag, "_dropped"}, ent_t'(pkt_dropped), '0);
    chk({tag, "_tready"}, ent_t'(s_tready), '0);
  endtask

  initial begin
    #3;
    chk_reset_outputs("rst0");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unicast to port 2
    send_pkt(5'b00100, 4, 1'b0);
    idle(6);

    // Multicast 0/1/4 with port 1 stalled for 20 cycles
    rdy[1] = 1'b0;
    send_pkt(5'b10011, 3, 1'b0);
    idle(20);
    rdy[1] = 1'b1;
    idle(6);

    // Fill port 3 to 66 entries, then a packet only for it must drop
    rdy[3] = 1'b0;
    send_pkt(5'b01000, 63, 1'b0);
    send_pkt(5'b01000, 3, 1'b0);
    idle(2);
    send_pkt(5'b01000, 5, 1'b0);
    send_pkt(5'b00010, 2, 1'b0);
    // Partial multicast: port 3 still pfull, port 1 takes it alone
    send_pkt(5'b01010, 3, 1'b0);
    idle(3);
    // No destination at all
    send_pkt(5'b00000, 2, 1'b0);
    rdy[3] = 1'b1;
    idle(70);

    // Single-beat packet followed immediately by a 2-beat packet
    send_pkt(5'b00001, 1, 1'b0);
    send_pkt(5'b10000, 2, 1'b0);
    idle(4);

    // Reset asserted mid-packet
    rdy = '0;
    drive_beat(5'b00100, 1'b1, 1'b0);
    tick();
    drive_beat(5'b00100, 1'b0, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    s_tvalid = 1'b0;
    model_reset();
    rdy = '1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    send_pkt(5'b00100, 3, 1'b0);
    idle(5);

    // Random traffic with random readiness and input bubbles
    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt(NQ'($urandom), ($urandom_range(0, 7) == 0) ? MAXW : $urandom_range(1, 12), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    rand_rdy = 1'b0;
    rdy = '1;
    idle(140);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/output_queues_demux.md
Name: output_queues_demux

Overview:
- Egress counterpart of the round-robin input arbiter: one AXI-Stream input, NUM_QUEUES AXI-Stream outputs (port 0 is the DMA lane, ports 1-4 are MAC TX).
- Reads the one-hot destination field in tuser at start of packet and copies the whole packet into every selected per-port FIFO (multicast allowed).
- Drops the packet when no selected port can accept a maximum-size packet.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master tdata width (equals slave width)
C_S_AXIS_DATA_WIDTH, 256, slave tdata width
C_M_AXIS_TUSER_WIDTH, 128, master tuser width (equals slave width)
C_S_AXIS_TUSER_WIDTH, 128, slave tuser width
NUM_QUEUES, 5, number of output ports (fixed port list 0..4)
DST_POS, 24, LSB index of the NUM_QUEUES-bit one-hot destination field in s_axis_tuser
MAX_PKT_WORDS, 63, beats in a 2000-byte packet at 32 B/beat
FIFO_DEPTH_BIT, 7, log2 of per-port FIFO depth (128 entries)

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  reset; asynchronous, active-low
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data
s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; destination one-hot at [DST_POS+NUM_QUEUES-1:DST_POS]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
m_axis_tdata_N  out  C_M_AXIS_DATA_WIDTH  port N data, N=0..4
m_axis_tstrb_N  out  C_M_AXIS_DATA_WIDTH/8  port N strobes
m_axis_tuser_N  out  C_M_AXIS_TUSER_WIDTH  port N metadata, passed through unmodified
m_axis_tvalid_N  out  1  port N valid
m_axis_tready_N  in  1  port N ready
m_axis_tlast_N  out  1  port N end of packet
pkt_stored  out  1  one-cycle pulse when a packet is accepted into at least one queue
pkt_dropped  out  1  one-cycle pulse when a packet is dropped entirely

Behaviour:
- Reset (axi_resetn low, asynchronous):
  - state=IDLE, dst_mask=0, pkt_stored=0, pkt_dropped=0.
  - All per-port FIFOs are emptied, so every m_axis_tvalid_N=0.
  - s_axis_tready=0 while reset is asserted.
- s_axis_tready=1 in every state out of reset. The block never backpressures the input; admission control is by dropping.
- Per-port FIFO, first-word fallthrough, entry={tlast,tuser,tstrb,tdata}.
  - pfull[N] is asserted when free entries < MAX_PKT_WORDS.
  - Write enable = beat_accept & dst_mask_eff[N] & ~full[N].
  - beat_accept = s_axis_tvalid & s_axis_tready.
- Output N:
  - m_axis_tvalid_N = ~empty[N]; data, tstrb, tuser and tlast come from the FIFO head.
  - FIFO read on m_axis_tvalid_N & m_axis_tready_N.
  - Ports are fully independent; a stalled port never blocks the others.
- FSM states: IDLE, WR_PKT, DROP_PKT.
  - IDLE, beat accepted: req = tuser destination field; acc = req & ~pfull.
    - acc!=0: write the beat to the acc queues, dst_mask<=acc, pkt_stored<=1 next cycle; next state = WR_PKT unless tlast (then stay IDLE).
    - acc==0 (including req==0): discard the beat, pkt_dropped<=1 next cycle; next state = DROP_PKT unless tlast (then stay IDLE).
  - WR_PKT: each accepted beat is written to the dst_mask queues. The tlast beat is written, then go to IDLE.
  - DROP_PKT: beats are discarded. On tlast, go to IDLE.
- Multicast partial acceptance: ports with pfull set at SOP miss the whole packet; the other selected ports receive it intact.
- The destination field is sampled only on the SOP beat; tuser on later beats is stored but does not affect routing.
- pfull is sampled only at SOP. A packet longer than MAX_PKT_WORDS that reaches a full FIFO loses those beats for that port; this is unsupported traffic, and there is no overflow or corruption of other ports.
- A FIFO read and write on the same cycle are both performed; occupancy is unchanged.
- Latency: an accepted beat is visible at m_axis_tvalid_N the cycle after the write.

Test Plan:
- Unicast: 4-beat packet, tuser[28:24]=5'b00100 -> 4 beats in order on port 2 only (tlast on beat 4), pkt_stored one pulse, ports 0/1/3/4 tvalid stay 0.
- Multicast plus stall: 3-beat packet with dst=5'b10011, m_axis_tready_1 held low for 20 cycles -> ports 0 and 4 finish in 4 cycles; port 1 emits the same 3 beats after its ready rises.
- Drop: fill port 3 to 66 entries (free 62<63), then send a 5-beat packet with dst=5'b01000 -> no writes, pkt_dropped one pulse, s_axis_tready stays 1, next packet to port 1 is stored.
- Partial multicast: port 3 pfull, dst=5'b01010 -> only port 1 receives the packet; pkt_stored=1, pkt_dropped=0.
- Single-beat and back-to-back: 1-beat packet (tlast on SOP) immediately followed by a 2-beat packet to another port -> state remains IDLE after the first; both delivered; two pkt_stored pulses.
- Reset mid-packet: assert axi_resetn=0 asynchronously on beat 2 of 6 -> all tvalid and pulse outputs 0 immediately; after release, state=IDLE and the next packet routes correctly with no leftover beats.
